// File: rtl/read_pointer_gen_pkg.sv
// Shared types for the read-pointer generator and its sibling pointer blocks.
package read_pointer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

endpackage

// File: rtl/read_pointer_gen_if.sv
// Control/status bundle between a buffer read controller and the pointer generator.
interface read_pointer_gen_if #(
    parameter int PTR_W  = 5,
    parameter int STEP_W = 2,
    parameter int CNT_W  = 4
);
    logic              ready;
    logic              halt;
    logic              clear;
    logic              mode;
    logic [STEP_W-1:0] step;
    logic [PTR_W-1:0]  read_pointer;
    logic              enable;
    logic              overflow;
    logic [CNT_W-1:0]  overflow_cnt;
    logic              done;

    modport master (
        output ready, halt, clear, mode, step,
        input  read_pointer, enable, overflow, overflow_cnt, done
    );

    modport slave (
        input  ready, halt, clear, mode, step,
        output read_pointer, enable, overflow, overflow_cnt, done
    );
endinterface

// File: rtl/read_pointer_gen_ptr_mod_add.sv
// Modulo-DEPTH pointer adder; shared by the read- and write-side pointer blocks.
module ptr_mod_add #(
    parameter int PTR_W  = 5,
    parameter int STEP_W = 2,
    parameter int DEPTH  = 32
) (
    input  logic [PTR_W-1:0]  ptr,
    input  logic [STEP_W-1:0] step,
    output logic [PTR_W-1:0]  ptr_nxt,
    output logic              wrap
);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0] sum;

    // One extra bit so ptr + step never truncates before the modulus compare.
    always_comb begin
        sum     = {1'b0, ptr} + (PTR_W+1)'(step);
        wrap    = (sum >= DEPTH_V);
        ptr_nxt = wrap ? PTR_W'(sum - DEPTH_V) : sum[PTR_W-1:0];
    end
endmodule

// File: rtl/read_pointer_gen.sv
// Read-pointer generator: run controller, modulo pointer, overflow pulse and saturating wrap count.
module read_pointer_gen
    import read_pointer_pkg::*;
#(
    parameter int PTR_W  = 5,
    parameter int DEPTH  = 32,
    parameter int STEP_W = 2,
    parameter int CNT_W  = 4
) (
    input logic              clk,
    input logic              resetn,
    read_pointer_gen_if.slave bus
);
    state_t           state;
    logic             mode_q;
    logic [PTR_W-1:0] ptr;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             en;
    logic             dn;
    logic [PTR_W-1:0] ptr_nxt;
    logic             wrap;

    ptr_mod_add #(
        .PTR_W  (PTR_W),
        .STEP_W (STEP_W),
        .DEPTH  (DEPTH)
    ) u_add (
        .ptr     (ptr),
        .step    (bus.step),
        .ptr_nxt (ptr_nxt),
        .wrap    (wrap)
    );

    // enable/done are kept as their own flops so every output is registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            mode_q <= MODE_WRAP;
            ptr    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
            en     <= 1'b0;
            dn     <= 1'b0;
        end else if (bus.clear) begin
            state <= IDLE;
            ptr   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            en    <= 1'b0;
            dn    <= 1'b0;
        end else if (bus.halt) begin
            state <= IDLE;
            ovf   <= 1'b0;
            en    <= 1'b0;
            dn    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ovf <= 1'b0;
                    if (bus.ready) begin
                        state  <= RUN;
                        mode_q <= bus.mode;
                        en     <= 1'b1;
                    end
                end
                RUN: begin
                    ptr <= ptr_nxt;
                    ovf <= wrap;
                    if (wrap && cnt != '1) cnt <= cnt + 1'b1;
                    if (wrap && mode_q == MODE_STOP) begin
                        state <= DONE;
                        en    <= 1'b0;
                        dn    <= 1'b1;
                    end
                end
                DONE: begin
                    ovf <= 1'b0;
                    // Level ready must drop before a new run can start.
                    if (!bus.ready) begin
                        state <= IDLE;
                        dn    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ovf   <= 1'b0;
                    en    <= 1'b0;
                    dn    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_pointer = ptr;
    assign bus.enable       = en;
    assign bus.overflow     = ovf;
    assign bus.overflow_cnt = cnt;
    assign bus.done         = dn;

    a_step_le_depth: assert property (@(posedge clk) disable iff (!resetn)
        32'(bus.step) <= DEPTH);
endmodule
